// File: rtl/icache_refill_arbiter.sv
// icache_refill_arbiter: I-cache line refill sequencer sharing one memory port with the data path.
// Ports: clk/rst (sync, active-high); ic_miss/ic_addr in from the I-cache, ic_fill_data/ic_from_mm/
// ic_data_ready out to it; d_req/d_we/d_addr/d_wdata in, d_rdata/d_done out for the data path;
// mem_req/mem_we/mem_addr/mem_wdata out, mem_gnt/mem_rvalid/mem_rdata in; busy and err status.
module icache_refill_arbiter #(
  parameter int ADDR_W = 14,
  parameter int BEATS = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ic_miss,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic [32*BEATS-1:0] ic_fill_data,
  output logic                ic_from_mm,
  output logic                ic_data_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [31:0]         d_wdata,
  output logic [31:0]         d_rdata,
  output logic                d_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [31:0]         mem_rdata,
  output logic                busy,
  output logic                err
);
  localparam int BW = $clog2(BEATS);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, I_REQ, I_FILL, I_DELIVER, D_REQ, D_WAIT, D_DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] wdog;
  logic [ADDR_W-1:0] line_addr;
  logic last_i, holdoff, pick_i, pick_d, waiting, timeout, beat, last_beat;
  always_comb begin
    pick_i = ic_miss && !holdoff && (!d_req || !last_i);
    pick_d = d_req && !pick_i;
    waiting = state == I_REQ || state == I_FILL || state == D_REQ || state == D_WAIT;
    timeout = waiting && wdog == WW'(TIMEOUT_CYC);
    beat = state == I_FILL && mem_rvalid && !timeout;
    last_beat = beat && beat_cnt == BW'(BEATS - 1);
    state_n = state;
    case (state)
      IDLE:      state_n = pick_i ? I_REQ : pick_d ? D_REQ : IDLE;
      I_REQ:     state_n = mem_gnt ? I_FILL : I_REQ;
      I_FILL:    state_n = last_beat ? I_DELIVER : I_FILL;
      I_DELIVER: state_n = IDLE;
      D_REQ:     state_n = !mem_gnt ? D_REQ : d_we ? D_DONE : D_WAIT;
      D_WAIT:    state_n = mem_rvalid ? D_DONE : D_WAIT;
      default:   state_n = IDLE;
    endcase
    if (timeout) state_n = IDLE;
    busy = state != IDLE;
    err = timeout;
    ic_from_mm = state == I_REQ || state == I_FILL || state == I_DELIVER;
    ic_data_ready = state == I_DELIVER;
    d_done = state == D_DONE;
    mem_req = (state == I_REQ || state == D_REQ) && !timeout;
    mem_we = state == D_REQ && d_we;
    mem_addr = state == I_REQ ? line_addr : state == D_REQ ? d_addr : '0;
    mem_wdata = state == D_REQ ? d_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat_cnt <= '0;
      wdog <= '0;
      last_i <= 1'b1;
      holdoff <= 1'b0;
      line_addr <= '0;
      ic_fill_data <= '0;
      d_rdata <= '0;
    end else begin
      state <= state_n;
      // cache needs one cycle after delivery to drop its miss flag
      holdoff <= state == I_DELIVER;
      wdog <= (waiting && state_n == state && !mem_gnt && !beat) ? wdog + WW'(1) : '0;
      if (state == IDLE && (pick_i || pick_d)) last_i <= pick_i;
      if (state == IDLE && pick_i) begin
        line_addr <= ic_addr & ~ADDR_W'(BEATS - 1);
        ic_fill_data <= '0;
      end
      if (state == I_REQ && mem_gnt) beat_cnt <= '0;
      // word 0 lands in the most significant slot
      if (beat) begin
        ic_fill_data[{~beat_cnt, 5'd0} +: 32] <= mem_rdata;
        beat_cnt <= beat_cnt + BW'(1);
      end
      if (state == D_WAIT && mem_rvalid && !timeout) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_icache_refill_arbiter.sv
// tb_icache_refill_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_icache_refill_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic ic_miss = 0, d_req = 0, d_we = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [13:0] ic_addr = 0, d_addr = 0, mem_addr;
  logic [31:0] d_wdata = 0, mem_rdata = 0, d_rdata, mem_wdata;
  logic [127:0] ic_fill_data;
  logic ic_from_mm, ic_data_ready, d_done, mem_req, mem_we, busy, err;
  int passed = 0, total = 0;

  icache_refill_arbiter dut (
    .clk(clk), .rst(rst), .ic_miss(ic_miss), .ic_addr(ic_addr), .ic_fill_data(ic_fill_data),
    .ic_from_mm(ic_from_mm), .ic_data_ready(ic_data_ready), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
  endtask

  // Reference model: one transaction record (who, phase, progress counters).
  // phase 0 none, 1 asking for the port, 2 collecting data, 3 completion cycle
  int phase = 0, wc = 0, nb = 0;
  bit is_i = 0, last_i = 1, skip = 0, mv = 0, to;
  logic [31:0] w [4];
  logic [31:0] m_rdata = 0;
  logic [13:0] la = 0;

  always @(negedge clk) begin
    to = (phase == 1 || phase == 2) && wc == 255;
    if (mv) begin
      chk("busy", busy, phase != 0);
      chk("err", err, to);
      chk("from_mm", ic_from_mm, is_i && phase != 0);
      chk("ready", ic_data_ready, is_i && phase == 3);
      chk("done", d_done, !is_i && phase == 3);
      chk("mem_req", mem_req, phase == 1 && !to);
      chk("mem_we", mem_we, phase == 1 && !is_i && d_we);
      chk("mem_addr", mem_addr, phase != 1 ? 14'h0 : is_i ? la : d_addr);
      chk("mem_wdata", mem_wdata, (phase == 1 && !is_i) ? d_wdata : 32'h0);
      chk("fill", ic_fill_data, {w[0], w[1], w[2], w[3]});
      chk("d_rdata", d_rdata, m_rdata);
    end
    if (rst) begin
      phase = 0; is_i = 0; last_i = 1; skip = 0; wc = 0; m_rdata = 0; la = 0; mv = 1;
      for (int i = 0; i < 4; i++) w[i] = 0;
    end else if (mv) begin
      if (to) phase = 0;
      else if (phase == 0) begin
        if (ic_miss && !skip && (!d_req || !last_i)) begin
          phase = 1; is_i = 1; last_i = 1; la = ic_addr & 14'h3FFC;
          for (int i = 0; i < 4; i++) w[i] = 0;
        end else if (d_req) begin
          phase = 1; is_i = 0; last_i = 0;
        end
        skip = 0; wc = 0;
      end else if (phase == 1) begin
        if (mem_gnt) begin phase = (!is_i && d_we) ? 3 : 2; nb = 0; wc = 0; end
        else wc++;
      end else if (phase == 2) begin
        if (mem_rvalid) begin
          wc = 0;
          if (is_i) begin w[nb] = mem_rdata; nb++; if (nb == 4) phase = 3; end
          else begin m_rdata = mem_rdata; phase = 3; end
        end else wc++;
      end else begin
        phase = 0; skip = is_i; wc = 0;
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  // runs a refill from IDLE; returns in the delivery cycle
  task automatic refill(input logic [13:0] a, input logic [13:0] ela, input int gd,
                        input logic [15:0] mask, input logic [31:0] base);
    int k;
    k = 0;
    ic_miss = 1; ic_addr = a; tick;
    #2; chk("ireq_addr", mem_addr, ela); chk("ireq_from_mm", ic_from_mm, 1);
    ic_addr = ~a;
    repeat (gd) tick;
    mem_gnt = 1; tick; mem_gnt = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      mem_rvalid = mask[c]; mem_rdata = base + k; tick;
      if (mask[c]) k++;
    end
    mem_rvalid = 0;
  endtask

  task automatic reset_dut; rst = 1; tick; tick; rst = 0; endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    tick; tick; rst = 0;
    #2; chk("rst_busy", busy, 0); chk("rst_fill", ic_fill_data, 0); chk("rst_rdata", d_rdata, 0);
    tick;
    // cold refill with holdoff while miss stays high
    refill(14'h0125, 14'h0124, 2, 16'h000F, 32'hA0);
    #2; chk("cold_line", ic_fill_data, 128'h000000A0_000000A1_000000A2_000000A3);
    chk("cold_ready", ic_data_ready, 1);
    tick; #2; chk("cold_ready_off", ic_data_ready, 0);
    tick; #2; chk("holdoff", busy, 0);
    ic_miss = 0; tick;
    // load
    d_req = 1; d_we = 0; d_addr = 14'h0200; tick;
    mem_gnt = 1; tick; mem_gnt = 0;
    repeat (3) tick;
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; tick; mem_rvalid = 0; d_req = 0;
    #2; chk("load_done", d_done, 1); chk("load_data", d_rdata, 32'hDEADBEEF);
    tick; #2; chk("load_done_off", d_done, 0); chk("load_hold", d_rdata, 32'hDEADBEEF);
    // store
    d_req = 1; d_we = 1; d_addr = 14'h0033; d_wdata = 32'h12345678; tick;
    #2; chk("store_we", mem_we, 1); chk("store_wdata", mem_wdata, 32'h12345678);
    mem_gnt = 1; tick; mem_gnt = 0; d_req = 0;
    #2; chk("store_done", d_done, 1);
    tick;
    // ties after reset: D first, then I while both keep asserting
    reset_dut;
    ic_miss = 1; ic_addr = 14'h0333; d_req = 1; d_we = 0; d_addr = 14'h0010; tick;
    #2; chk("tie1_d", mem_addr, 14'h0010); chk("tie1_not_i", ic_from_mm, 0);
    mem_gnt = 1; tick; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h55; tick; mem_rvalid = 0;
    d_we = 1; d_addr = 14'h0044; d_wdata = 32'h77; tick;
    refill(14'h0333, 14'h0330, 0, 16'h000F, 32'hC0);
    ic_miss = 0; tick; tick;
    #2; chk("tie_store_we", mem_we, 1);
    mem_gnt = 1; tick; mem_gnt = 0;
    #2; chk("tie_store_done", d_done, 1); chk("tie_rdata_hold", d_rdata, 32'h55);
    d_req = 0; tick;
    // gapped beats
    refill(14'h1FFF, 14'h1FFC, 1, 16'h0232, 32'hB0);
    #2; chk("gap_line", ic_fill_data, 128'h000000B0_000000B1_000000B2_000000B3);
    chk("gap_ready", ic_data_ready, 1);
    ic_miss = 0; tick; tick;
    // watchdog then retry
    ic_miss = 1; ic_addr = 14'h0042; tick;
    n = 0; seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      #2;
      if (err) seen = 1;
      else begin n += int'(mem_req); tick; end
    end
    chk("wd_seen", seen, 1); chk("wd_cycles", n, 255); chk("wd_req_drop", mem_req, 0);
    tick; #2; chk("wd_no_ready", ic_data_ready, 0);
    refill(14'h0042, 14'h0040, 1, 16'h000F, 32'hE0);
    #2; chk("wd_retry_line", ic_fill_data, 128'h000000E0_000000E1_000000E2_000000E3);
    ic_miss = 0; tick; tick;
    // reset after beat 2
    ic_miss = 1; ic_addr = 14'h0100; tick;
    mem_gnt = 1; tick; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'hF0; tick; mem_rdata = 32'hF1; tick; mem_rvalid = 0;
    rst = 1; tick;
    #2; chk("mid_busy", busy, 0); chk("mid_fill", ic_fill_data, 0);
    chk("mid_ready", ic_data_ready, 0); chk("mid_from_mm", ic_from_mm, 0); chk("mid_req", mem_req, 0);
    rst = 0; ic_miss = 0; tick; tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icache_refill_arbiter.md
Name: icache_refill_arbiter

Overview:
- Memory-side controller for the L1 instruction cache.
- Sequences a 4-word line refill from main memory into the cache when the cache raises a miss. Drives the cache's fill-data, from-MM and data-ready inputs.
- Shares the single main-memory port between I-cache refills and the data-side load/store path. Arbitration is round-robin, and a watchdog aborts stuck transactions.

Parameters:
- ADDR_W, 14, word-address width; matches the cache address (tag 10, set 2, word 2).
- BEATS, 4, words per cache line; the line is 128 bits.
- TIMEOUT_CYC, 255, maximum cycles spent waiting for mem_gnt or mem_rvalid before abort.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_miss  in  1  miss flag from the I-cache (level).
- ic_addr  in  14  fetch address presented to the I-cache.
- ic_fill_data  out  128  line to the cache; word0 at [127:96], word3 at [31:0].
- ic_from_mm  out  1  refill mode; to the cache fromMM input.
- ic_data_ready  out  1  one-cycle pulse: ic_fill_data is valid.
- d_req  in  1  data-side request (level, held until d_done).
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  14  data word address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, valid when d_done is high.
- d_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request (level until mem_gnt).
- mem_we  out  1  write enable to memory.
- mem_addr  out  14  memory word address.
- mem_wdata  out  32  memory write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs are 0, including ic_fill_data and d_rdata.
  - beat_cnt = 0, wdog = 0, last_win = I, so D wins the first tie.
  - Reset mid-transaction abandons it silently: no done, ready or err pulse.
- IDLE arbitration, one cycle:
  - Only an eligible ic_miss → I_REQ.
  - Only d_req → D_REQ.
  - Both → the side that is not last_win; last_win updates on the grant decision.
  - ic_miss is ignored in the first IDLE cycle after I_DELIVER (holdoff while the cache clears miss).
- I_REQ:
  - Drive mem_req=1, mem_we=0, mem_addr={ic_addr[13:2],2'b00}; this line address is latched on entry.
  - ic_from_mm=1 from I_REQ entry through I_DELIVER inclusive.
  - mem_gnt → I_FILL, with beat_cnt=0 and mem_req dropping the next cycle.
- I_FILL:
  - Each mem_rvalid writes mem_rdata into ic_fill_data[127-32*beat_cnt -: 32], then beat_cnt++.
  - Beat BEATS-1 → I_DELIVER.
  - Cycles without rvalid are allowed.
  - ic_fill_data is cleared to 0 on I_REQ entry.
- I_DELIVER, exactly one cycle:
  - ic_data_ready=1 and ic_from_mm=1; ic_fill_data holds the complete line.
  - → IDLE.
- D_REQ:
  - Drive mem_req=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
  - On mem_gnt: a store → D_DONE; a load → D_WAIT.
- D_WAIT: the first mem_rvalid latches d_rdata=mem_rdata → D_DONE.
- D_DONE, one cycle: d_done=1 → IDLE. d_rdata holds until the next load completes.
- mem_rvalid in IDLE, I_REQ or D_REQ is ignored; memory is required not to send it there.
- Watchdog:
  - wdog counts cycles in I_REQ, I_FILL, D_REQ and D_WAIT, clearing on each mem_gnt, each accepted rvalid, and each state change.
  - wdog==TIMEOUT_CYC → err pulse, mem_req=0, → IDLE, with no ready or done pulse.
  - The requester, still asserting, re-arbitrates, so a refill retries from beat 0.
- Widths: beat_cnt 2 bits, wdog 8 bits; no wrap occurs because abort fires at TIMEOUT_CYC.
- An ic_addr change during a refill has no effect; the latched line address is used.

Test Plan:
- Cold refill: ic_miss=1, ic_addr=14'h0125, mem_gnt after 2 cycles, beats 32'hA0..A3 on consecutive cycles → mem_addr=14'h0124. ic_fill_data=128'h000000A0_000000A1_000000A2_000000A3. ic_data_ready pulses exactly one cycle, 1 cycle after the last beat. ic_from_mm high from I_REQ through I_DELIVER.
- Load: d_req=1, d_we=0, d_addr=14'h0200, rdata 32'hDEADBEEF after 3 idle cycles → d_rdata=32'hDEADBEEF and d_done one-cycle pulse. Store of 32'h12345678 → mem_we=1, d_done 1 cycle after mem_gnt.
- Tie after reset: ic_miss and d_req rise together → D served first, then the refill. A second simultaneous tie → I served first.
- Gapped beats: rvalid on cycles 1, 4, 5, 9 → words placed in order, no early ready.
- Watchdog: mem_gnt never asserted → err pulses at wait cycle 255 and mem_req drops. With ic_miss still high, the refill restarts from beat 0 and completes normally afterwards.
- Reset asserted after beat 2 of a refill → next cycle all outputs are 0 and state is IDLE, with no ic_data_ready.
